// File: rtl/comb_decim_out_stage.sv
// Output stage of the comb polyphase branch: drops pipeline-fill samples, decimates by DEC,
// rounds/saturates to OUT_W and buffers results in a 2-entry valid/ready FIFO.
//
// state    | meaning
// ST_PRIME | discarding branch fill samples; prime_cnt counts down on each en
// ST_RUN   | decimating; an accepted sample is kept when phase is 0
module comb_decim_out_stage #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 10,
    parameter int DEC   = 4,
    parameter int SHIFT = 7,
    parameter int PRIME = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  in_comb,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    output logic                    sat_flag,
    output logic                    drop_flag
);

    localparam int PW  = (PRIME > 0) ? $clog2(PRIME + 1) : 1;
    localparam int PHW = (DEC > 1) ? $clog2(DEC) : 1;

    localparam logic [PW-1:0]         PRIME_INIT = PW'(PRIME);
    localparam logic [PHW-1:0]        PHASE_LAST = PHW'(DEC - 1);
    localparam logic signed [IN_W:0]  RND        = (IN_W + 1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0]  OMAX       = (IN_W + 1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0]  OMIN       = (IN_W + 1)'(-(2 ** (OUT_W - 1)));

    typedef enum logic [0:0] {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // With no fill latency the block starts directly in the decimating state.
    localparam state_t ST_START = (PRIME > 0) ? ST_PRIME : ST_RUN;

    state_t          state_q, state_d;
    logic [PW-1:0]   prime_cnt_q, prime_cnt_d;
    logic [PHW-1:0]  phase_q, phase_d;
    logic            keep;

    logic signed [IN_W:0]   in_ext;
    logic signed [IN_W:0]   sum;
    logic signed [IN_W:0]   shr;
    logic signed [OUT_W-1:0] rnd_val;
    logic                   clip;

    logic                    pipe_vld_q;
    logic signed [OUT_W-1:0] pipe_data_q;

    logic signed [OUT_W-1:0] head_q;
    logic signed [OUT_W-1:0] tail_q;
    logic [1:0]              cnt_q;
    logic                    push;
    logic                    pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_START;
            prime_cnt_q <= PRIME_INIT;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        phase_d     = phase_q;
        keep        = 1'b0;
        if (clr) begin
            state_d     = ST_START;
            prime_cnt_d = PRIME_INIT;
            phase_d     = '0;
        end else if (en) begin
            case (state_q)
                ST_PRIME: begin
                    prime_cnt_d = prime_cnt_q - PW'(1);
                    if (prime_cnt_q == PW'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    keep    = (phase_q == '0);
                    phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PHW'(1);
                end
                default: begin
                    state_d = ST_START;
                end
            endcase
        end
    end

    // One extra bit of headroom so the rounding offset cannot wrap at full scale.
    assign in_ext = {in_comb[IN_W-1], in_comb};
    assign sum    = in_ext + RND;
    assign shr    = sum >>> SHIFT;

    always_comb begin
        rnd_val = shr[OUT_W-1:0];
        clip    = 1'b0;
        if (shr > OMAX) begin
            rnd_val = OMAX[OUT_W-1:0];
            clip    = 1'b1;
        end else if (shr < OMIN) begin
            rnd_val = OMIN[OUT_W-1:0];
            clip    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= '0;
            sat_flag    <= 1'b0;
        end else if (clr) begin
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= '0;
            sat_flag    <= 1'b0;
        end else begin
            pipe_vld_q <= keep;
            if (keep) begin
                pipe_data_q <= rnd_val;
                if (clip) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

    assign push      = pipe_vld_q;
    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = head_q;

    // head_q is always the oldest entry, so out_data comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= 2'd0;
            drop_flag <= 1'b0;
        end else if (clr) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= 2'd0;
            drop_flag <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_q <= pipe_data_q;
                        cnt_q  <= 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        tail_q <= pipe_data_q;
                        cnt_q  <= 2'd2;
                    end else begin
                        drop_flag <= 1'b1;
                    end
                end
                2'b01: begin
                    if (cnt_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= pipe_data_q;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= pipe_data_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
